// File: rtl/timer_dev_if.sv
// CPU data-bus interface of the programmable timer.
// The CPU side drives the master modport, the timer uses the slave modport.
interface timer_dev_if;
  logic [1:0]  addr;  // word address bits [3:2], selects register 0..3
  logic        we;    // write strobe
  logic [31:0] din;   // write data
  logic [31:0] dout;  // combinational read data
  logic        irq;   // level-sensitive interrupt request

  modport master (output addr, output we, output din, input dout, input irq);
  modport slave  (input addr, input we, input din, output dout, output irq);
endinterface

// File: rtl/timer_dev.sv
// Programmable 32-bit down-counting timer with a CPU register interface.
// Registers: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT (read-only), 3 reserved.
// Optional feature macro TIMER_RELOAD_EN: when defined, MODE=1 reloads PRESET
// after every expiry; when undefined every MODE value runs as one-shot.
module timer_dev (
  input  logic        clk,
  input  logic        rst,
  timer_dev_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CNT,
    S_INT
  } state_e;

  state_e      state_q;
  logic        en_q;
  logic [1:0]  mode_q;
  logic        im_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic        irqf_q;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        reload_sel;

  assign ctrl_wr   = bus.we && (bus.addr == 2'd0);
  assign preset_wr = bus.we && (bus.addr == 2'd1);

`ifdef TIMER_RELOAD_EN
  assign reload_sel = (mode_q == 2'd1);
`else
  // MODE is still stored and read back, but never selects auto-reload.
  assign reload_sel = 1'b0;
`endif

  // Control/status registers and the counting FSM, all under synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      irqf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en_q) state_q <= S_LOAD;
        end
        S_LOAD: begin
          count_q <= preset_q;
          state_q <= S_CNT;
        end
        S_CNT: begin
          if (!en_q) begin
            state_q <= S_IDLE;
          end else if (count_q <= 32'd1) begin
            // A count of 0 expires like a count of 1; never wraps to 2^32-1.
            count_q <= 32'd0;
            state_q <= S_INT;
          end else begin
            count_q <= count_q - 32'd1;
          end
        end
        S_INT: begin
          irqf_q <= 1'b1;
          if (reload_sel) begin
            state_q <= S_LOAD;
          end else begin
            en_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // NOTE: these writes come after the FSM on purpose; with non-blocking
      // assignments the last one in the block wins, so a CTRL write landing in
      // the INT cycle keeps the written EN/MODE/IM and clears IRQF.
      if (ctrl_wr) begin
        en_q   <= bus.din[0];
        mode_q <= bus.din[2:1];
        im_q   <= bus.din[3];
        irqf_q <= 1'b0;
      end
      if (preset_wr) preset_q <= bus.din;
    end
  end

  // Read mux; reserved address returns zero.
  always_comb begin
    // NOTE: default first so every path assigns dout and no latch is inferred.
    bus.dout = 32'd0;
    unique case (bus.addr)
      2'd0:    bus.dout = {28'd0, im_q, mode_q, en_q};
      2'd1:    bus.dout = preset_q;
      2'd2:    bus.dout = count_q;
      default: bus.dout = 32'd0;
    endcase
  end

  // Interrupt is the sticky flag gated by the mask.
  assign bus.irq = irqf_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios followed by random
// register traffic, all compared against a behavioural model of the timer.
module tb_timer_dev;

  logic clk = 1'b0;
  logic rst = 1'b1;

  timer_dev_if bus ();

  timer_dev dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef TIMER_RELOAD_EN
  localparam bit RELOAD_BUILD = 1'b1;
`else
  localparam bit RELOAD_BUILD = 1'b0;
`endif

  // Reference model: programmer-visible registers plus the timer's phase.
  localparam int PH_WAIT   = 0;  // waiting for EN
  localparam int PH_RELOAD = 1;  // COUNT takes PRESET on the next edge
  localparam int PH_RUN    = 2;  // counting down
  localparam int PH_FIRE   = 3;  // expiry edge: flag raised next

  bit          m_en;
  bit [1:0]    m_mode;
  bit          m_im;
  bit [31:0]   m_preset;
  bit [31:0]   m_count;
  bit          m_irqf;
  int          m_phase;

  int    total = 0;
  int    bad   = 0;
  string phase_tag = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%h expected=%h", phase_tag, tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge with the inputs present at that edge.
  task automatic model_edge(input bit r, input bit w, input logic [1:0] a, input logic [31:0] d);
    if (r) begin
      m_en = 0; m_mode = 0; m_im = 0; m_preset = 0; m_count = 0; m_irqf = 0;
      m_phase = PH_WAIT;
      return;
    end
    if (m_phase == PH_WAIT) begin
      if (m_en) m_phase = PH_RELOAD;
    end else if (m_phase == PH_RELOAD) begin
      m_count = m_preset;
      m_phase = PH_RUN;
    end else if (m_phase == PH_RUN) begin
      if (!m_en)              m_phase = PH_WAIT;
      else if (m_count > 1)   m_count = m_count - 1;
      else begin              m_count = 0; m_phase = PH_FIRE; end
    end else begin
      m_irqf = 1;
      if (RELOAD_BUILD && m_mode == 2'd1) m_phase = PH_RELOAD;
      else begin m_en = 0; m_phase = PH_WAIT; end
    end
    // Bus writes are applied last so they override the expiry side effects.
    if (w && a == 2'd0) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_irqf = 0;
    end
    if (w && a == 2'd1) m_preset = d;
  endtask

  // One clock: drive inputs, take the edge, then read back register rd.
  task automatic step(input bit r, input bit w, input logic [1:0] a,
                      input logic [31:0] d, input logic [1:0] rd);
    @(negedge clk);
    rst = r; bus.we = w; bus.addr = a; bus.din = d;
    @(posedge clk);
    model_edge(r, w, a, d);
    #1;
    rst = 1'b0; bus.we = 1'b0; bus.addr = rd;
    #1;
    check($sformatf("dout[%0d]", rd), bus.dout, model_read(rd));
    check("irq", {31'd0, bus.irq}, {31'd0, m_irqf & m_im});
  endtask

  task automatic idle(input int n, input logic [1:0] rd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'd0, rd);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [1:0] rd);
    step(1'b0, 1'b1, a, d, rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.we = 1'b0; bus.addr = 2'd0; bus.din = 32'd0;
    m_phase = PH_WAIT;

    // Reset with a write pending: every register reads 0.
    phase_tag = "reset";
    step(1'b1, 1'b1, 2'd1, 32'hDEAD_BEEF, 2'd0);
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 1'b0, 2'd0, 32'd0, 2'(a));
      check("reset_zero", bus.dout, 32'd0);
    end

    // One-shot, PRESET=5, IM set.
    phase_tag = "oneshot5";
    wr(2'd1, 32'd5, 2'd2);
    wr(2'd0, 32'h9, 2'd2);            // E0
    idle(2, 2'd2);                    // E1, E2
    check("count_at_e2", bus.dout, 32'd5);
    idle(5, 2'd2);                    // E3..E7
    check("irq_before_e8", {31'd0, bus.irq}, 32'd0);
    idle(1, 2'd0);                    // E8
    check("irq_at_e8", {31'd0, bus.irq}, 32'd1);
    check("ctrl_after", bus.dout, 32'h8);
    idle(4, 2'd2);
    wr(2'd0, 32'h0, 2'd0);
    check("irq_cleared", {31'd0, bus.irq}, 32'd0);

    // Masked interrupt, then unmasking does not raise irq.
    phase_tag = "masked";
    wr(2'd1, 32'd10, 2'd1);
    wr(2'd0, 32'h1, 2'd2);
    idle(15, 2'd2);
    wr(2'd0, 32'h8, 2'd0);
    idle(2, 2'd0);
    check("irq_unmask", {31'd0, bus.irq}, 32'd0);

    // Stop mid-count, then restart reloads PRESET.
    phase_tag = "stop";
    wr(2'd1, 32'd100, 2'd2);
    wr(2'd0, 32'h1, 2'd2);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0, 1'b0, 2'd0, 32'd0, 2'd2);
      found = (m_count == 32'd41);
    end
    check("wait_count41", {31'd0, found}, 32'd1);
    wr(2'd0, 32'h0, 2'd2);
    idle(3, 2'd2);
    check("count_held", bus.dout, 32'd40);
    wr(2'd0, 32'h1, 2'd2);
    idle(2, 2'd2);
    check("count_reload", bus.dout, 32'd100);
    wr(2'd0, 32'h0, 2'd2);

    // PRESET=0 expires like PRESET=1.
    phase_tag = "preset0";
    wr(2'd1, 32'd0, 2'd2);
    wr(2'd0, 32'h9, 2'd2);
    idle(3, 2'd2);
    check("irq_before_e4", {31'd0, bus.irq}, 32'd0);
    idle(1, 2'd2);
    check("irq_at_e4", {31'd0, bus.irq}, 32'd1);

    // Writes to COUNT and reserved are ignored.
    phase_tag = "ro";
    wr(2'd2, 32'h1234_5678, 2'd2);
    wr(2'd3, 32'hFFFF_FFFF, 2'd3);
    check("reserved", bus.dout, 32'd0);

    // CTRL write landing on the expiry edge wins.
    phase_tag = "int_race";
    wr(2'd1, 32'd3, 2'd2);
    wr(2'd0, 32'h9, 2'd2);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b0, 1'b0, 2'd0, 32'd0, 2'd2);
      found = (m_phase == PH_FIRE);
    end
    check("wait_int", {31'd0, found}, 32'd1);
    wr(2'd0, 32'hD, 2'd0);
    check("ctrl_kept", bus.dout, 32'hD);
    check("irqf_clear", {31'd0, bus.irq}, 32'd0);

    // Auto-reload (or one-shot fallback) over several periods.
    phase_tag = "reload";
    wr(2'd0, 32'h0, 2'd2);
    wr(2'd1, 32'd3, 2'd2);
    wr(2'd0, 32'hB, 2'd2);
    idle(16, 2'd2);
    idle(1, 2'd0);

    // Reset while the flag is set, with a simultaneous PRESET write.
    phase_tag = "rst_busy";
    step(1'b1, 1'b1, 2'd1, 32'd77, 2'd1);
    check("preset_discard", bus.dout, 32'd0);
    check("irq_reset", {31'd0, bus.irq}, 32'd0);
    wr(2'd1, 32'd50, 2'd2);
    wr(2'd0, 32'h9, 2'd2);
    idle(12, 2'd2);
    step(1'b1, 1'b0, 2'd0, 32'd0, 2'd2);
    check("count_reset", bus.dout, 32'd0);

    // Random register traffic.
    phase_tag = "random";
    for (int i = 0; i < 600; i++) begin
      bit          r;
      bit          w;
      logic [1:0]  a;
      logic [31:0] d;
      r = ($urandom_range(0, 79) == 0);
      w = ($urandom_range(0, 3) == 0);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 12);
      step(r, w, a, d, 2'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
